// File: rtl/mips_run_monitor_pkg.sv
// Shared types and defaults for the MIPS run monitor.
// Holds the FSM state enum, default parameter values and the saturating increment helper.
package mips_mon_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RST_HOLD,
        RUN,
        CHECK,
        DONE
    } mon_state_t;

    localparam int DEF_DATA_W      = 32;
    localparam int DEF_NUM_CH      = 6;
    localparam int DEF_RST_CYCLES  = 4;
    localparam int DEF_HALT_CYCLES = 8;
    localparam int DEF_TIMEOUT     = 4096;
    localparam int DEF_CNT_W       = 32;

    // Increment that sticks at the all-ones value of a w-bit counter.
    function automatic logic [63:0] sat_inc(input logic [63:0] cnt, input int unsigned w);
        logic [63:0] lim;
        lim = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        return (cnt >= lim) ? cnt : cnt + 64'd1;
    endfunction

endpackage

// File: rtl/mips_run_monitor_if.sv
// Control/observation bundle between the run monitor and its driver (core side + stimulus).
// MIPS_MON_PC_HIST_EN adds the pc_hist / halt_instr debug outputs.
interface mips_run_monitor_if #(
    parameter int DATA_W = mips_mon_pkg::DEF_DATA_W,
    parameter int NUM_CH = mips_mon_pkg::DEF_NUM_CH,
    parameter int CNT_W  = mips_mon_pkg::DEF_CNT_W
);
    logic                     start;
    logic [DATA_W-1:0]        pc_in;
    logic [DATA_W-1:0]        instr_in;
    logic [NUM_CH*DATA_W-1:0] reg_in;
    logic [NUM_CH*DATA_W-1:0] exp_in;
    logic                     core_reset;
    logic                     running;
    logic                     done;
    logic                     pass;
    logic                     timed_out;
    logic [NUM_CH-1:0]        fail_mask;
    logic [CNT_W-1:0]         cycle_count;
`ifdef MIPS_MON_PC_HIST_EN
    logic [4*DATA_W-1:0]      pc_hist;
    logic [DATA_W-1:0]        halt_instr;

    modport master (
        output start, pc_in, instr_in, reg_in, exp_in,
        input  core_reset, running, done, pass, timed_out, fail_mask, cycle_count,
        input  pc_hist, halt_instr
    );
    modport slave (
        input  start, pc_in, instr_in, reg_in, exp_in,
        output core_reset, running, done, pass, timed_out, fail_mask, cycle_count,
        output pc_hist, halt_instr
    );
`else
    modport master (
        output start, pc_in, instr_in, reg_in, exp_in,
        input  core_reset, running, done, pass, timed_out, fail_mask, cycle_count
    );
    modport slave (
        input  start, pc_in, instr_in, reg_in, exp_in,
        output core_reset, running, done, pass, timed_out, fail_mask, cycle_count
    );
`endif
endinterface

// File: rtl/mips_run_monitor_halt_detect.sv
// PC-stable detector: halted pulses on the cycle the PC has been unchanged HALT_CYCLES cycles.
// Latency: combinational on the last matching cycle; no backpressure.
module mips_halt_detect #(
    parameter int DATA_W      = 32,
    parameter int HALT_CYCLES = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              en,
    input  logic [DATA_W-1:0] pc_in,
    output logic              halted
);
    localparam int HW = $clog2(HALT_CYCLES);

    logic [DATA_W-1:0] prev_pc;
    logic              prev_vld;
    logic [HW-1:0]     hold_cnt;
    logic              pc_same;

    // The first enabled cycle after a clear only captures a reference PC.
    assign pc_same = prev_vld && (pc_in == prev_pc);
    assign halted  = en && pc_same && (hold_cnt == HW'(HALT_CYCLES - 2));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_pc  <= '0;
            prev_vld <= 1'b0;
            hold_cnt <= '0;
        end else if (clear) begin
            prev_vld <= 1'b0;
            hold_cnt <= '0;
        end else if (en) begin
            prev_pc  <= pc_in;
            prev_vld <= 1'b1;
            if (!pc_same)
                hold_cnt <= '0;
            else if (hold_cnt != HW'(HALT_CYCLES - 1))
                hold_cnt <= hold_cnt + HW'(1);
        end
    end
endmodule

// File: rtl/mips_run_monitor.sv
// Run controller / result checker for the 5-stage MIPS core; MIPS_MON_PC_HIST_EN adds PC history.
// Latency: core_reset rises one edge after start; earliest done RST_CYCLES+HALT_CYCLES+1 edges later.
// Backpressure: none; start outside IDLE/DONE is dropped.
module mips_run_monitor
    import mips_mon_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int NUM_CH      = DEF_NUM_CH,
    parameter int RST_CYCLES  = DEF_RST_CYCLES,
    parameter int HALT_CYCLES = DEF_HALT_CYCLES,
    parameter int TIMEOUT     = DEF_TIMEOUT,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic                  clk,
    input  logic                  reset,
    mips_run_monitor_if.slave     mon
);
    localparam int RCW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    mon_state_t        state, state_nxt;
    logic [RCW-1:0]    rst_cnt;
    logic [CNT_W-1:0]  cyc_q;
    logic              to_q;
    logic              pass_q;
    logic [NUM_CH-1:0] mask_q;
    logic [NUM_CH-1:0] cmp_mask;
    logic              start_ok;
    logic              halted;
    logic              timeout_hit;
    logic              in_run;

    assign start_ok    = mon.start && ((state == IDLE) || (state == DONE));
    assign in_run      = (state == RUN);
    assign timeout_hit = (cyc_q == CNT_W'(TIMEOUT - 1));

    mips_halt_detect #(
        .DATA_W      (DATA_W),
        .HALT_CYCLES (HALT_CYCLES)
    ) u_halt (
        .clk    (clk),
        .reset  (reset),
        .clear  (start_ok),
        .en     (in_run),
        .pc_in  (mon.pc_in),
        .halted (halted)
    );

    always_comb begin
        cmp_mask = '0;
        for (int i = 0; i < NUM_CH; i++)
            cmp_mask[i] = (mon.reg_in[i*DATA_W +: DATA_W] != mon.exp_in[i*DATA_W +: DATA_W]);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: if (mon.start) state_nxt = RST_HOLD;
            RST_HOLD:   if (rst_cnt == RCW'(RST_CYCLES - 1)) state_nxt = RUN;
            RUN:        if (halted || timeout_hit) state_nxt = CHECK;
            CHECK:      state_nxt = DONE;
            default:    state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rst_cnt <= '0;
            cyc_q   <= '0;
            to_q    <= 1'b0;
            pass_q  <= 1'b0;
            mask_q  <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (mon.start) begin
                        rst_cnt <= '0;
                        cyc_q   <= '0;
                        to_q    <= 1'b0;
                        pass_q  <= 1'b0;
                        mask_q  <= '0;
                    end
                end
                RST_HOLD: rst_cnt <= rst_cnt + RCW'(1);
                RUN: begin
                    cyc_q <= CNT_W'(sat_inc(64'(cyc_q), CNT_W));
                    // A halt seen on the timeout cycle still counts as a clean halt.
                    if (timeout_hit && !halted) to_q <= 1'b1;
                end
                CHECK: begin
                    mask_q <= cmp_mask;
                    pass_q <= ~to_q & ~|cmp_mask;
                end
                default: ;
            endcase
        end
    end

`ifdef MIPS_MON_PC_HIST_EN
    logic [4*DATA_W-1:0] hist_q;
    logic [DATA_W-1:0]   hinstr_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hist_q   <= '0;
            hinstr_q <= '0;
        end else if (start_ok) begin
            hist_q   <= '0;
            hinstr_q <= '0;
        end else if (in_run) begin
            if (mon.pc_in != hist_q[DATA_W-1:0])
                hist_q <= {hist_q[3*DATA_W-1:0], mon.pc_in};
            if (halted || timeout_hit)
                hinstr_q <= mon.instr_in;
        end
    end

    assign mon.pc_hist    = hist_q;
    assign mon.halt_instr = hinstr_q;
`endif

    assign mon.core_reset  = (state == IDLE) || (state == RST_HOLD);
    assign mon.running     = in_run;
    assign mon.done        = (state == DONE);
    assign mon.pass        = pass_q;
    assign mon.timed_out   = to_q;
    assign mon.fail_mask   = mask_q;
    assign mon.cycle_count = cyc_q;
endmodule

// File: tb/tb_mips_run_monitor.sv
// Scoreboard bench for mips_run_monitor: each run pushes its predicted result, popped at done.
module tb_mips_run_monitor;
    localparam int DW   = 32;
    localparam int NCH  = 6;
    localparam int RSTC = 4;
    localparam int HALT = 8;
    localparam int TO   = 64;
    localparam int CW   = 32;

    typedef struct {
        bit              pass;
        bit              to;
        logic [NCH-1:0]  mask;
        int              cc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_err = 0;
    exp_t sb[$];

    mips_run_monitor_if #(.DATA_W(DW), .NUM_CH(NCH), .CNT_W(CW)) bus ();

    mips_run_monitor #(
        .DATA_W(DW), .NUM_CH(NCH), .RST_CYCLES(RSTC),
        .HALT_CYCLES(HALT), .TIMEOUT(TO), .CNT_W(CW)
    ) dut (
        .clk   (clk),
        .reset (rst_n),
        .mon   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_core_reset"}, bus.core_reset, 1);
        chk({tag, "_running"},    bus.running, 0);
        chk({tag, "_done"},       bus.done, 0);
        chk({tag, "_pass"},       bus.pass, 0);
        chk({tag, "_timed_out"},  bus.timed_out, 0);
        chk({tag, "_fail_mask"},  bus.fail_mask, 0);
        chk({tag, "_cycle_cnt"},  bus.cycle_count, 0);
    endtask

    function automatic logic [DW-1:0] pc_of(input int k, input int steps, input bit halt_en);
        int kk;
        if (!halt_en) return DW'(32'h400 + 4 * k);
        kk = (k > steps) ? steps : k;
        return DW'(32'h400 + 4 * (kk - 1));
    endfunction

    // steps: distinct PCs before the hold; halt_en=0 never repeats the PC.
    // abort_at: pull reset at that RUN cycle; restart_at: pulse start at that RUN cycle.
    task automatic run_case(input string tag, input int steps, input bit halt_en,
                            input logic [NCH-1:0] bad, input int abort_at, input int restart_at);
        exp_t        e;
        exp_t        got_e;
        logic [DW-1:0] ev;
        int          hold;
        int          lat;
        int          k;
        bit          seen;

        for (int i = 0; i < NCH; i++) begin
            ev = (i == 2) ? DW'(32'h7) : DW'($urandom);
            bus.exp_in[i*DW +: DW] = ev;
            bus.reg_in[i*DW +: DW] = bad[i] ? (ev ^ DW'(32'h2)) : ev;
        end

        if (!halt_en || (steps + HALT - 1 > TO)) begin
            e.cc = TO;
            e.to = 1'b1;
        end else begin
            e.cc = steps + HALT - 1;
            e.to = 1'b0;
        end
        e.mask = bad;
        e.pass = !e.to && (bad == '0);
        sb.push_back(e);

        @(negedge clk) bus.start = 1'b1;
        @(negedge clk) bus.start = 1'b0;
        chk({tag, "_clr_done"}, bus.done, 0);
        chk({tag, "_clr_cc"},   bus.cycle_count, 0);
        chk({tag, "_clr_mask"}, bus.fail_mask, 0);
        chk({tag, "_clr_pass"}, bus.pass, 0);

        hold = 0;
        lat  = 1;
        while (bus.core_reset && hold < 20) begin
            hold++;
            @(negedge clk);
            lat++;
        end
        chk({tag, "_rst_hold"}, hold, RSTC);
        chk({tag, "_running"}, bus.running, 1);

        k = 1;
        seen = 0;
        for (int n = 0; n < 5000 && !seen; n++) begin
            if (bus.done) begin
                seen = 1;
            end else begin
                if (abort_at != 0 && k == abort_at) begin
                    #2 rst_n = 1'b0;
                    #1 chk_reset_vals({tag, "_abort"});
                    void'(sb.pop_back());
                    @(negedge clk) rst_n = 1'b1;
                    return;
                end
                bus.pc_in = pc_of(k, steps, halt_en);
                bus.instr_in = DW'($urandom);
                bus.start = (restart_at != 0 && k == restart_at);
                @(negedge clk);
                lat++;
                k++;
            end
        end
        bus.start = 1'b0;

        got_e = sb.pop_front();
        if (!seen) begin
            chk({tag, "_done_wait"}, 0, 1);
            return;
        end
        chk({tag, "_pass"},      bus.pass, got_e.pass);
        chk({tag, "_timed_out"}, bus.timed_out, got_e.to);
        chk({tag, "_fail_mask"}, bus.fail_mask, got_e.mask);
        chk({tag, "_cycle_cnt"}, bus.cycle_count, got_e.cc);
        chk({tag, "_latency"},   lat, RSTC + got_e.cc + 2);
        chk({tag, "_core_rst0"}, bus.core_reset, 0);
        chk({tag, "_run0"},      bus.running, 0);
        for (int j = 0; j < 3; j++) begin
            bus.pc_in = bus.pc_in + DW'(4);
            @(negedge clk);
            chk({tag, "_frozen_cc"},   bus.cycle_count, got_e.cc);
            chk({tag, "_frozen_done"}, bus.done, 1);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start    = 1'b0;
        bus.pc_in    = '0;
        bus.instr_in = '0;
        bus.reg_in   = '0;
        bus.exp_in   = '0;

        repeat (3) begin
            @(negedge clk);
            chk_reset_vals("por");
        end
        rst_n = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk_reset_vals("idle");
        end

        run_case("clean",     20, 1'b1, 6'b000000, 0, 0);
        run_case("bad_ch2",   20, 1'b1, 6'b000100, 0, 0);
        run_case("timeout",    0, 1'b0, 6'b000000, 0, 0);
        run_case("earliest",   1, 1'b1, 6'b000000, 0, 0);
        run_case("halt_wins", 57, 1'b1, 6'b000000, 0, 0);
        run_case("halt_late", 58, 1'b1, 6'b000000, 0, 0);
        run_case("abort",     20, 1'b1, 6'b000000, 10, 0);
        run_case("rerun",     20, 1'b1, 6'b000000, 0, 0);
        run_case("restart",   20, 1'b1, 6'b100001, 0, 5);

        chk("sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
